// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic lab datapath: nibble width and sequencer state encoding.
package arith_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// CLA_4bit: combinational 4-bit carry-lookahead adder, zero latency, no flow control.
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = A ^ B;
    assign w_g = A & B;

    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign Cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign S = w_p ^ w_c;

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract around one CLA_4bit; done pulses NIB edges after the accepting edge.
// start is only honoured in IDLE/DONE (back-to-back allowed); a start during RUN is dropped.
module cla_seq_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NIB - 1);

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_carry, w_carry_nxt;
    logic [WIDTH-1:0]   r_a, w_a_nxt;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic [WIDTH-1:0]   r_sum, w_sum_nxt;
    logic               r_cout, w_cout_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_cout4;
    logic                w_c_msb_in;

    assign w_a_nib = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_b_nib = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

    CLA_4bit u_cla (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout4)
    );

    // Only meaningful on the last pass, where w_s[3] is the MSB sum bit.
    assign w_c_msb_in = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[NIBBLE_W-1];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            ST_RUN: begin
                w_sum_nxt[NIBBLE_W*r_idx +: NIBBLE_W] = w_s;
                w_carry_nxt = w_cout4;
                if (r_idx == IDX_MAX) begin
                    w_cout_nxt  = w_cout4;
                    w_ovf_nxt   = w_c_msb_in ^ w_cout4;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = sub ? ~b : b;
                    w_carry_nxt = sub;
                    w_idx_nxt   = '0;
                    w_sum_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt == ST_RUN);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_carry <= w_carry_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized and directed bench for cla_seq_adder against an integer-arithmetic reference model.
module tb_cla_seq_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks;
    int failures;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned/signed interpretations.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                  output logic [15:0] r, output logic c, output logic v);
        int ux, uy, sx, sy, ures, sres;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (s) begin
            ures = ux - uy;
            sres = sx - sy;
            c    = (ux >= uy);
        end else begin
            ures = ux + uy;
            sres = sx + sy;
            c    = (ures >= 65536);
        end
        r = 16'(ures & 32'hFFFF);
        v = (sres > 32767) || (sres < -32768);
    endfunction

    // Called at #1 after a posedge with the DUT idle.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          input string tag);
        int k;
        logic [15:0] es;
        logic ec, ev;
        model(ia, ib, isub, es, ec, ev);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(NIB));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ev));
        @(posedge clk); #1;
        chk({tag, "_dn_low"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        logic        ps [6];
        logic [15:0] es;
        logic        ec, ev;
        int          k, ndone;
        logic [15:0] seen_sum;

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {27'd0, busy, done, cout, ovf, 1'b0}, 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h4321, 1'b0, "t1");
        run_op(16'hFFFF, 16'h0001, 1'b0, "t2a");
        run_op(16'h7FFF, 16'h0001, 1'b0, "t2b");
        run_op(16'h0005, 16'h0007, 1'b1, "t3a");
        run_op(16'h8000, 16'h0001, 1'b1, "t3b");
        run_op(16'h1234, 16'h0000, 1'b1, "sub0");

        // Start pulse mid-RUN must be ignored.
        model(16'h0F0F, 16'h0101, 1'b0, es, ec, ev);
        start = 1'b1; a = 16'h0F0F; b = 16'h0101; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; seen_sum = '0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin ndone++; seen_sum = sum; end
            @(posedge clk); #1;
        end
        chk("t4_ndone", 32'(ndone), 32'd1);
        chk("t4_sum", 32'(seen_sum), 32'(es));

        // Reset mid-operation.
        run_op(16'h7FFF, 16'h0001, 1'b0, "t5pre");
        start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_outs", {28'd0, busy, done, cout, ovf}, 32'd0);
        chk("t5_rst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("t5_quiet", 32'(ndone), 32'd0);
        run_op(16'hABCD, 16'h1111, 1'b1, "t5post");

        // Back-to-back with start held high.
        for (int i = 0; i < 6; i++) begin
            pa[i] = (i % 2 == 0) ? 16'h1357 : 16'($urandom);
            pb[i] = (i % 2 == 0) ? 16'hECA9 : 16'($urandom);
            ps[i] = 1'(i % 2);
        end
        start = 1'b1; a = pa[0]; b = pb[0]; sub = ps[0];
        for (int i = 0; i < 6; i++) begin
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (!done && k < 20);
            model(pa[i], pb[i], ps[i], es, ec, ev);
            chk($sformatf("t6_lat%0d", i), 32'(k), 32'(NIB + 1));
            chk($sformatf("t6_sum%0d", i), {15'd0, cout, sum}, {15'd0, ec, es});
            chk($sformatf("t6_ovf%0d", i), 32'(ovf), 32'(ev));
            if (i < 5) begin a = pa[i+1]; b = pb[i+1]; sub = ps[i+1]; end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // Randomized operations, with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'hFFFF;
            if (i % 8 == 2) rb = ra;
            run_op(ra, rb, 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
